// File: rtl/square_arbiter_if.sv
// rtl/square_arbiter_if.sv - request/response bus between requesters and square_arbiter
//
// Purpose: bundles the per-requester request lanes and the shared result lane.
// Ports (signals):
//   req_valid    [REQ_NUM]          request strobe per requester
//   req_radicand [REQ_NUM*2*WIDTH]  packed radicands, requester k at [k*2*WIDTH +: 2*WIDTH]
//   req_ready    [REQ_NUM]          one-hot grant
//   resp_valid                      result strobe
//   resp_id      [ID_W]             requester that issued the result
//   resp_root    [WIDTH]            floor(sqrt(radicand))
//   inflight     [clog2(WIDTH+1)]   accepted requests not yet returned
// Modports: master = requester side, slave = arbiter side.

interface square_arbiter_if #(
  parameter int WIDTH   = 4,
  parameter int REQ_NUM = 2,
  parameter int ID_W    = 1
);
  logic [REQ_NUM-1:0]           req_valid;
  logic [REQ_NUM*2*WIDTH-1:0]   req_radicand;
  logic [REQ_NUM-1:0]           req_ready;
  logic                         resp_valid;
  logic [ID_W-1:0]              resp_id;
  logic [WIDTH-1:0]             resp_root;
  logic [$clog2(WIDTH+1)-1:0]   inflight;

  modport master (
    output req_valid, req_radicand,
    input  req_ready, resp_valid, resp_id, resp_root, inflight
  );

  modport slave (
    input  req_valid, req_radicand,
    output req_ready, resp_valid, resp_id, resp_root, inflight
  );
endinterface

// File: rtl/square_arbiter.sv
// rtl/square_arbiter.sv - round-robin arbiter feeding one shared pipelined integer square root
//
// square_extractor: non-restoring square root, one pipeline stage per root bit,
//   latency WIDTH cycles, no stall.
//   clk, rst_n (async, active-low), radicand [2*WIDTH] in, root [WIDTH] out.
// square_arbiter: grants one requester per cycle and tags each result with its ID.
//   clk, rst (async, active-high), bus (square_arbiter_if.slave).
// Build option: define SQUARE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
//   no pointer state); default is round-robin.

module square_extractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*WIDTH-1:0]   radicand,
  output logic [WIDTH-1:0]     root
);
  // Remainder stays within +/-2**(WIDTH+2); one extra bit of headroom.
  localparam int RW = WIDTH + 4;

  // Stage s registers; the last stage only keeps its root, so only q has WIDTH entries.
  logic signed [RW-1:0]  r_q [WIDTH-1];
  logic [2*WIDTH-1:0]    x_q [WIDTH-1];
  logic [WIDTH-1:0]      q_q [WIDTH];

  logic signed [RW-1:0]  r_d [WIDTH];
  logic [2*WIDTH-1:0]    x_d [WIDTH];
  logic [WIDTH-1:0]      q_d [WIDTH];

  logic signed [RW-1:0]  r_i [WIDTH];
  logic [2*WIDTH-1:0]    x_i [WIDTH];
  logic [WIDTH-1:0]      q_i [WIDTH];

  logic signed [RW-1:0]  r_sh;
  logic signed [RW-1:0]  r_nx;

  always_comb begin
    r_sh = '0;
    r_nx = '0;
    r_i[0] = '0;
    q_i[0] = '0;
    x_i[0] = radicand;
    for (int s = 1; s < WIDTH; s++) begin
      r_i[s] = r_q[s-1];
      q_i[s] = q_q[s-1];
      x_i[s] = x_q[s-1];
    end
    for (int s = 0; s < WIDTH; s++) begin
      // Bring down the next radicand bit pair (x is kept left-aligned).
      r_sh = (r_i[s] <<< 2) | RW'(x_i[s][2*WIDTH-1 -: 2]);
      // Non-restoring step: a negative remainder is corrected by adding instead of restoring.
      if (r_i[s][RW-1]) r_nx = r_sh + RW'({q_i[s], 2'b11});
      else              r_nx = r_sh - RW'({q_i[s], 2'b01});
      q_d[s] = {q_i[s][WIDTH-2:0], ~r_nx[RW-1]};
      r_d[s] = r_nx;
      x_d[s] = x_i[s] << 2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < WIDTH-1; s++) begin
        r_q[s] <= '0;
        x_q[s] <= '0;
      end
      for (int s = 0; s < WIDTH; s++) q_q[s] <= '0;
    end else begin
      for (int s = 0; s < WIDTH-1; s++) begin
        r_q[s] <= r_d[s];
        x_q[s] <= x_d[s];
      end
      for (int s = 0; s < WIDTH; s++) q_q[s] <= q_d[s];
    end
  end

  assign root = q_q[WIDTH-1];
endmodule

module square_arbiter #(
  parameter int WIDTH   = 4,
  parameter int REQ_NUM = 2,
  parameter int ID_W    = 1
) (
  input  logic            clk,
  input  logic            rst,
  square_arbiter_if.slave bus
);
  localparam int IW = $clog2(WIDTH + 1);

  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_idx;
  logic [REQ_NUM-1:0]   ready;
  logic                 hs;
  logic [2*WIDTH-1:0]   sel_radicand;
  logic [WIDTH-1:0]     root;
  logic                 rst_n;
  int                   idx;

  logic [WIDTH-1:0]     vld_q, vld_d;
  logic [ID_W-1:0]      id_q [WIDTH];
  logic [ID_W-1:0]      id_d [WIDTH];
  logic [IW-1:0]        inflight_q, inflight_d;
`ifndef SQUARE_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]      ptr_q, ptr_d;
`endif

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
`ifdef SQUARE_ARB_FIXED_PRIO_EN
      idx = i;
`else
      // Search starts at the pointer and wraps around.
      idx = (int'(ptr_q) + i) % REQ_NUM;
`endif
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
    // Grant is masked during reset since it is purely combinational.
    hs = gnt_found && !rst;
    for (int i = 0; i < REQ_NUM; i++) ready[i] = hs && (gnt_idx == ID_W'(i));
    sel_radicand = bus.req_radicand[int'(gnt_idx)*(2*WIDTH) +: 2*WIDTH];

`ifndef SQUARE_ARB_FIXED_PRIO_EN
    ptr_d = ptr_q;
    if (hs) ptr_d = (int'(gnt_idx) == REQ_NUM-1) ? '0 : gnt_idx + 1'b1;
`endif

    vld_d = {vld_q[WIDTH-2:0], hs};
    id_d[0] = gnt_idx;
    for (int i = 1; i < WIDTH; i++) id_d[i] = id_q[i-1];

    inflight_d = inflight_q;
    case ({hs, vld_q[WIDTH-1]})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < WIDTH; i++) id_q[i] <= '0;
`ifndef SQUARE_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < WIDTH; i++) id_q[i] <= id_d[i];
`ifndef SQUARE_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign rst_n = ~rst;

  square_extractor #(.WIDTH(WIDTH)) u_sqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .radicand (sel_radicand),
    .root     (root)
  );

  assign bus.req_ready  = ready;
  assign bus.resp_valid = vld_q[WIDTH-1];
  assign bus.resp_id    = id_q[WIDTH-1];
  assign bus.resp_root  = root;
  assign bus.inflight   = inflight_q;
endmodule

// File: tb/tb_square_arbiter.sv
// tb/tb_square_arbiter.sv - directed and scoreboarded checks for square_arbiter

module tb_square_arbiter;
  localparam int WIDTH   = 4;
  localparam int REQ_NUM = 2;
  localparam int ID_W    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  square_arbiter_if #(.WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .ID_W(ID_W)) bus ();

  square_arbiter #(.WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int due;
    int id;
    int root;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_n   = 0;
  int   rad30  [3] = '{0, 255, 15};
  int   root30 [3] = '{0, 15, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [7:0] r0, input logic [7:0] r1);
    bus.req_valid    = v;
    bus.req_radicand = {r1, r0};
    #1;
  endtask

  task automatic check_resp(input string tag, input int id, input int root);
    check({tag, "_valid"}, bus.resp_valid, 1);
    check({tag, "_id"},    bus.resp_id,    id);
    check({tag, "_root"},  bus.resp_root,  root);
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic sb_tick;
    tick;
    check("t033_inflight", bus.inflight, exp_q.size());
    if (exp_q.size() != 0 && exp_q[0].due == edge_n) begin
      check_resp("t033_resp", exp_q[0].id, exp_q[0].root);
      void'(exp_q.pop_front());
    end else begin
      check("t033_idle_valid", bus.resp_valid, 0);
    end
    edge_n++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int last_gnt;
    int eg;
    logic [1:0] v;
    logic [7:0] r0, r1;

    // Reset state, with requests pending to show the grant is masked.
    set_req(2'b11, 8'd9, 8'd16);
    tick;
    check("rst_ready",      bus.req_ready,  0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_id",    bus.resp_id,    0);
    check("rst_inflight",   bus.inflight,   0);
    set_req(2'b00, 8'd0, 8'd0);
    rst = 1'b0;

    // Single request from req0: 144 -> 12 four edges later.
    set_req(2'b01, 8'd144, 8'd0);
    check("t028_ready", bus.req_ready, 2'b01);
    tick;
    set_req(2'b00, 8'd0, 8'd0);
    check("t028_idle_ready", bus.req_ready, 0);
    for (int j = 0; j < 3; j++) begin
      check("t028_inflight", bus.inflight, 1);
      check("t028_early_valid", bus.resp_valid, 0);
      tick;
    end
    check("t028_inflight", bus.inflight, 1);
    check_resp("t028_resp", 0, 12);
    tick;
    check("t028_after_valid", bus.resp_valid, 0);
    check("t028_after_inflight", bus.inflight, 0);

`ifndef SQUARE_ARB_FIXED_PRIO_EN
    // Both requesters continuously valid: grants alternate from 0.
    rst = 1'b1;
    #1;
    tick;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_req(2'b11, 8'd49, 8'd200);
      check("t029_ready", bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      tick;
      if (c >= 3) check_resp("t029_resp", (c - 3) % 2, ((c - 3) % 2 == 0) ? 7 : 14);
      else check("t029_early_valid", bus.resp_valid, 0);
      check("t029_inflight", bus.inflight, (c + 1 < 4) ? c + 1 : 4);
    end
    set_req(2'b00, 8'd0, 8'd0);
    for (int c = 8; c < 11; c++) begin
      tick;
      check_resp("t029_drain", (c - 3) % 2, ((c - 3) % 2 == 0) ? 7 : 14);
      check("t029_drain_inflight", bus.inflight, 11 - c);
    end
    tick;
    check("t029_end_valid", bus.resp_valid, 0);
    check("t029_end_inflight", bus.inflight, 0);
`else
    // Fixed priority: req0 wins while valid, req1 only after it drops.
    for (int c = 0; c < 6; c++) begin
      set_req(2'b11, 8'd49, 8'd200);
      check("t032_ready", bus.req_ready, 2'b01);
      tick;
    end
    set_req(2'b10, 8'd49, 8'd200);
    check("t032_req1_ready", bus.req_ready, 2'b10);
    tick;
    set_req(2'b00, 8'd0, 8'd0);
    repeat (6) tick;
    check("t032_inflight", bus.inflight, 0);
`endif

    // Back-to-back boundary radicands from req1.
    for (int c = 0; c < 3; c++) begin
      set_req(2'b10, 8'd0, rad30[c][7:0]);
      check("t030_ready", bus.req_ready, 2'b10);
      tick;
      check("t030_early_valid", bus.resp_valid, 0);
    end
    set_req(2'b00, 8'd0, 8'd0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check_resp("t030_resp", 1, root30[c]);
    end
    tick;
    check("t030_end_valid", bus.resp_valid, 0);

    // Reset with three requests in flight and the pointer parked at 1.
    for (int c = 0; c < 3; c++) begin
      set_req(2'b01, 8'd100, 8'd0);
      check("t031_ready", bus.req_ready, 2'b01);
      tick;
    end
    check("t031_inflight_pre", bus.inflight, 3);
    set_req(2'b00, 8'd0, 8'd0);
    rst = 1'b1;
    #1;
    check("t031_rst_inflight", bus.inflight, 0);
    check("t031_rst_valid", bus.resp_valid, 0);
    tick;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      check("t031_post_valid", bus.resp_valid, 0);
      check("t031_post_inflight", bus.inflight, 0);
    end
    set_req(2'b11, 8'd4, 8'd9);
    check("t031_first_grant", bus.req_ready, 2'b01);
    tick;
    set_req(2'b00, 8'd0, 8'd0);
    tick;
    tick;
    tick;
    check_resp("t031_resp", 0, 2);
    tick;
    check("t031_end_inflight", bus.inflight, 0);

    // Random traffic against a floor(sqrt) scoreboard; last grant above went to 0.
    last_gnt = 0;
    for (int n = 0; n < 300; n++) begin
      v  = 2'($urandom_range(0, 3));
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r0 = 8'd255;
      if ($urandom_range(0, 7) == 0) r1 = 8'd0;
      set_req(v, r0, r1);
      case (v)
        2'b00: eg = 0;
        2'b01: eg = 1;
        2'b10: eg = 2;
`ifdef SQUARE_ARB_FIXED_PRIO_EN
        default: eg = 1;
`else
        default: eg = (last_gnt == 0) ? 2 : 1;
`endif
      endcase
      check("t033_grant", bus.req_ready, eg);
      if (eg != 0) begin
        last_gnt = (eg == 2) ? 1 : 0;
        exp_q.push_back('{due: edge_n + 3, id: last_gnt,
                          root: isqrt((eg == 2) ? int'(r1) : int'(r0))});
      end
      sb_tick;
    end
    set_req(2'b00, 8'd0, 8'd0);
    repeat (6) sb_tick;
    check("t033_all_returned", exp_q.size(), 0);
    check("t033_end_inflight", bus.inflight, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
